// File: rtl/status_pkg.sv
// Shared types and defaults for the status subsystem (arbiter, splitter, detect).
package status_pkg;

    localparam int NUM_CH_DEF  = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 64;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_idx(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/status_bram_wr_arbiter_if.sv
// Request/BRAM-write bundle between the channel controllers and the write-port arbiter.
interface status_bram_wr_arbiter_if
    import status_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NUM_CH-1:0]        req_start;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_done;
    logic                     bram_wr_start;
    logic [ADDR_W-1:0]        bram_wr_addr;
    logic [DATA_W-1:0]        bram_wr_data;
    logic                     bram_wr_done;
    logic                     clear_err;
    logic                     busy;
    logic [NUM_CH-1:0]        overflow_err;
    logic                     timeout_err;

    modport master (
        output req_start, req_addr, req_data, bram_wr_done, clear_err,
        input  req_done, bram_wr_start, bram_wr_addr, bram_wr_data,
               busy, overflow_err, timeout_err
    );

    modport slave (
        input  req_start, req_addr, req_data, bram_wr_done, clear_err,
        output req_done, bram_wr_start, bram_wr_addr, bram_wr_data,
               busy, overflow_err, timeout_err
    );
endinterface

// File: rtl/status_rr_pick.sv
// Combinational round-robin selector: first set pend bit at or after rr_ptr, cyclic.
module status_rr_pick
    import status_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int PTR_W  = ptr_w(NUM_CH_DEF)
) (
    input  logic [NUM_CH-1:0] pend,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [PTR_W-1:0]  grant,
    output logic              any_req
);

    // Scan from the farthest offset down so the nearest pending channel wins.
    always_comb begin
        int idx;
        grant = '0;
        idx   = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (pend[idx]) begin
                grant = PTR_W'(idx);
            end
        end
    end

    assign any_req = |pend;

endmodule

// File: rtl/status_bram_wr_arbiter.sv
// Shares one BRAM write port among NUM_CH channel controllers, round-robin,
// one write in flight, with timeout guard and sticky overflow/timeout flags.
module status_bram_wr_arbiter
    import status_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    status_bram_wr_arbiter_if.slave   bus
);

    localparam int         PTR_W  = ptr_w(NUM_CH);
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    grant_reg, grant_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]    pick;
    logic                any_req;
    logic [7:0]          wait_cnt_reg, wait_cnt_next;
    logic                wr_start_reg, wr_start_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
    logic [NUM_CH-1:0]   req_done_reg, req_done_next;
    logic                timeout_err_reg, timeout_err_next;
    logic                complete;
    logic                timeout_hit;

    logic [NUM_CH-1:0]   pend;
    logic [NUM_CH-1:0]   ovf_err;
    logic [ADDR_W-1:0]   addr_q [NUM_CH];
    logic [DATA_W-1:0]   data_q [NUM_CH];

    status_rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .pend    (pend),
        .rr_ptr  (rr_ptr_reg),
        .grant   (pick),
        .any_req (any_req)
    );

    // Per-channel holding registers; a start landing on the completing channel is accepted.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              complete_ch;
            logic              accept;
            logic              pend_reg;
            logic              ovf_err_reg;
            logic [ADDR_W-1:0] addr_q_reg;
            logic [DATA_W-1:0] data_q_reg;

            assign complete_ch = complete && (grant_reg == PTR_W'(gi));
            assign accept      = bus.req_start[gi] && (!pend_reg || complete_ch);

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_reg    <= 1'b0;
                    ovf_err_reg <= 1'b0;
                end else begin
                    if (accept) begin
                        pend_reg <= 1'b1;
                    end else if (complete_ch) begin
                        pend_reg <= 1'b0;
                    end
                    ovf_err_reg <= (ovf_err_reg && !bus.clear_err)
                                 || (bus.req_start[gi] && !accept);
                end
            end

            always_ff @(posedge clk) begin
                if (accept) begin
                    addr_q_reg <= bus.req_addr[gi*ADDR_W +: ADDR_W];
                    data_q_reg <= bus.req_data[gi*DATA_W +: DATA_W];
                end
            end

            assign pend[gi]    = pend_reg;
            assign ovf_err[gi] = ovf_err_reg;
            assign addr_q[gi]  = addr_q_reg;
            assign data_q[gi]  = data_q_reg;
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        rr_ptr_next      = rr_ptr_reg;
        wait_cnt_next    = wait_cnt_reg;
        wr_start_next    = 1'b0;
        wr_addr_next     = wr_addr_reg;
        wr_data_next     = wr_data_reg;
        req_done_next    = '0;
        complete         = 1'b0;
        timeout_hit      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next    = pick;
                    wr_start_next = 1'b1;
                    wr_addr_next  = addr_q[pick];
                    wr_data_next  = data_q[pick];
                    wait_cnt_next = '0;
                    state_next    = WAIT;
                end
            end
            WAIT: begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
                // A real done in the timeout cycle still counts as a clean completion.
                if (bus.bram_wr_done || (wait_cnt_reg == TO_CNT)) begin
                    complete                 = 1'b1;
                    timeout_hit              = !bus.bram_wr_done;
                    req_done_next[grant_reg] = 1'b1;
                    rr_ptr_next              = PTR_W'(next_idx(int'(grant_reg), NUM_CH));
                    state_next               = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        timeout_err_next = (timeout_err_reg && !bus.clear_err) || timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            rr_ptr_reg      <= '0;
            wait_cnt_reg    <= '0;
            wr_start_reg    <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            req_done_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            rr_ptr_reg      <= rr_ptr_next;
            wait_cnt_reg    <= wait_cnt_next;
            wr_start_reg    <= wr_start_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
            req_done_reg    <= req_done_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign bus.req_done      = req_done_reg;
    assign bus.bram_wr_start = wr_start_reg;
    assign bus.bram_wr_addr  = wr_addr_reg;
    assign bus.bram_wr_data  = wr_data_reg;
    assign bus.overflow_err  = ovf_err;
    assign bus.timeout_err   = timeout_err_reg;
    assign bus.busy          = (|pend) || (state_reg != IDLE);

endmodule
